lfsr_prbs_engine: RTL and testbench

- Parametrised Fibonacci LFSR PRBS block with two independent halves: a generator and a self-synchronising checker.
- Generator: the LFSR stepper with two additions: runtime seed load and all-zero lock-up protection.
- Checker: aligns to an incoming serial PRBS stream, declares lock, counts bit errors and detects loss of sync.
- Sits between link/BIST logic and the serial datapath for loopback and pattern testing.

---
 rtl/lfsr_prbs_pkg.sv | 32 +++
 rtl/lfsr_prbs_engine_checker.sv | 138 +++++++++++++
 rtl/lfsr_prbs_engine.sv | 72 +++++++
 tb/tb_lfsr_prbs_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_prbs_pkg.sv
// Shared types and the LFSR feedback helper for the PRBS generator/checker.
// The feedback function works on a fixed maximum width, so LFSR_LENGTH must
// not exceed LFSR_MAX_W.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;
    localparam int LFSR_IDX_W = 6;

    typedef enum logic [1:0] {
        CHK_HUNT   = 2'd0,
        CHK_VERIFY = 2'd1,
        CHK_LOCKED = 2'd2
    } chk_state_t;

    // Fibonacci feedback: the top bit is always tapped, bits 1..msb-1 are
    // tapped where poly has a one, and bit 0 (constant term) is ignored.
    function automatic logic lfsr_fb(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] poly,
        input logic [LFSR_IDX_W-1:0] msb
    );
        logic fb;
        fb = state[msb];
        for (int i = 1; i < LFSR_MAX_W - 1; i++) begin
            if ((i < int'(msb)) && poly[i]) begin
                fb = fb ^ state[i];
            end
        end
        return fb;
    endfunction

endpackage

// File: rtl/lfsr_prbs_engine_checker.sv
// Self-synchronising PRBS checker: fills its own LFSR from the received
// stream, verifies the prediction for LOCK_COUNT bits, then tracks errors
// while locked and falls back to hunting after LOSS_THRESH misses in a row.
module lfsr_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int                     LFSR_LENGTH    = 16,
    parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = 16'hD009,
    parameter int                     LOCK_COUNT     = 32,
    parameter int                     LOSS_THRESH    = 8,
    parameter int                     ERR_CNT_W      = 16
) (
    input  logic                 lfsr_clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic                 rx_bit,
    input  logic                 cnt_clr,
    output logic                 chk_locked,
    output logic                 chk_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [LFSR_IDX_W-1:0] MSB_IDX  = LFSR_IDX_W'(LFSR_LENGTH - 1);
    localparam logic [LFSR_MAX_W-1:0] POLY_EXT = LFSR_MAX_W'(LFSR_PRIM_POLY);

    // Counters run 0..N-1; the last value marks the Nth event.
    localparam int FILL_W  = (LFSR_LENGTH > 1) ? $clog2(LFSR_LENGTH) : 1;
    localparam int MATCH_W = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)  : 1;
    localparam int MISS_W  = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_LENGTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

    chk_state_t             state_q;
    logic [LFSR_LENGTH-1:0] c_q;
    logic [FILL_W-1:0]      fill_q;
    logic [MATCH_W-1:0]     match_q;
    logic [MISS_W-1:0]      miss_q;

    logic                   exp_bit;
    logic                   bit_ok;
    logic                   locked_miss;
    logic [LFSR_LENGTH-1:0] c_shift;
    logic [LFSR_LENGTH-1:0] c_step;

    // Prediction of the next received bit and the two ways c can advance.
    always_comb begin
        exp_bit     = lfsr_fb(LFSR_MAX_W'(c_q), POLY_EXT, MSB_IDX);
        bit_ok      = (rx_bit == exp_bit);
        c_shift     = {c_q[LFSR_LENGTH-2:0], rx_bit};
        c_step      = {c_q[LFSR_LENGTH-2:0], exp_bit};
        locked_miss = rx_valid && (state_q == CHK_LOCKED) && !bit_ok;
    end

    // Checker FSM: hunt/verify/locked with fill, match and miss counters.
    always_ff @(posedge lfsr_clk) begin
        if (reset) begin
            state_q    <= CHK_HUNT;
            c_q        <= '0;
            fill_q     <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            chk_locked <= 1'b0;
            chk_err    <= 1'b0;
        end else begin
            chk_err <= 1'b0;
            if (rx_valid) begin
                case (state_q)
                    CHK_HUNT: begin
                        c_q <= c_shift;
                        if (fill_q == FILL_LAST) begin
                            fill_q <= '0;
                            // An all-zero fill would self-predict zeros forever,
                            // so it is refused and the hunt simply restarts.
                            if (c_shift != '0) begin
                                state_q <= CHK_VERIFY;
                                match_q <= '0;
                            end
                        end else begin
                            fill_q <= fill_q + 1'b1;
                        end
                    end
                    CHK_VERIFY: begin
                        c_q <= c_step;
                        if (bit_ok) begin
                            if (match_q == MATCH_LAST) begin
                                state_q    <= CHK_LOCKED;
                                chk_locked <= 1'b1;
                                match_q    <= '0;
                                miss_q     <= '0;
                            end else begin
                                match_q <= match_q + 1'b1;
                            end
                        end else begin
                            state_q <= CHK_HUNT;
                            fill_q  <= '0;
                        end
                    end
                    CHK_LOCKED: begin
                        c_q <= c_step;
                        if (!bit_ok) begin
                            chk_err <= 1'b1;
                            if (miss_q == MISS_LAST) begin
                                state_q    <= CHK_HUNT;
                                fill_q     <= '0;
                                miss_q     <= '0;
                                chk_locked <= 1'b0;
                            end else begin
                                miss_q <= miss_q + 1'b1;
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                    default: begin
                        state_q    <= CHK_HUNT;
                        fill_q     <= '0;
                        chk_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear wins over a same-cycle error and
    // losing lock leaves the count intact.
    always_ff @(posedge lfsr_clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (locked_miss && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_prbs_engine.sv
// PRBS engine top: inline Fibonacci LFSR generator with seed load and
// zero-seed protection, plus an independent self-synchronising checker.
// Loopback between the two halves is done outside this block.
module lfsr_prbs_engine
    import lfsr_pkg::*;
#(
    parameter int                     LFSR_LENGTH    = 16,
    parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = 16'hD009,
    parameter logic [LFSR_LENGTH-1:0] LFSR_SEED_VAL  = 16'hACE1,
    parameter int                     LOCK_COUNT     = 32,
    parameter int                     LOSS_THRESH    = 8,
    parameter int                     ERR_CNT_W      = 16
) (
    input  logic                   lfsr_clk,
    input  logic                   reset,
    input  logic                   lfsr_en,
    input  logic                   seed_load,
    input  logic [LFSR_LENGTH-1:0] seed_val,
    output logic [LFSR_LENGTH-1:0] lfsr_state_out,
    output logic                   lfsr_out,
    input  logic                   rx_valid,
    input  logic                   rx_bit,
    input  logic                   cnt_clr,
    output logic                   chk_locked,
    output logic                   chk_err,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam logic [LFSR_IDX_W-1:0] MSB_IDX  = LFSR_IDX_W'(LFSR_LENGTH - 1);
    localparam logic [LFSR_MAX_W-1:0] POLY_EXT = LFSR_MAX_W'(LFSR_PRIM_POLY);

    logic [LFSR_LENGTH-1:0] lfsr_q;
    logic                   gen_fb;

    // Generator feedback from the current register contents.
    always_comb begin
        gen_fb = lfsr_fb(LFSR_MAX_W'(lfsr_q), POLY_EXT, MSB_IDX);
    end

    // Generator register: seed load beats step; a zero seed would lock the
    // LFSR up, so the reset seed is substituted for it.
    always_ff @(posedge lfsr_clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED_VAL;
        end else if (seed_load) begin
            lfsr_q <= (seed_val == '0) ? LFSR_SEED_VAL : seed_val;
        end else if (lfsr_en) begin
            lfsr_q <= {lfsr_q[LFSR_LENGTH-2:0], gen_fb};
        end
    end

    assign lfsr_state_out = lfsr_q;
    assign lfsr_out       = lfsr_q[LFSR_LENGTH-1];

    lfsr_prbs_checker #(
        .LFSR_LENGTH    (LFSR_LENGTH),
        .LFSR_PRIM_POLY (LFSR_PRIM_POLY),
        .LOCK_COUNT     (LOCK_COUNT),
        .LOSS_THRESH    (LOSS_THRESH),
        .ERR_CNT_W      (ERR_CNT_W)
    ) u_checker (
        .lfsr_clk   (lfsr_clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .cnt_clr    (cnt_clr),
        .chk_locked (chk_locked),
        .chk_err    (chk_err),
        .err_cnt    (err_cnt)
    );

endmodule

// File: tb/tb_lfsr_prbs_engine.sv
// Directed bench for lfsr_prbs_engine with a 4-bit LFSR (x^4+x^3+1).
module tb_lfsr_prbs_engine;

    logic       lfsr_clk;
    logic       reset;
    logic       lfsr_en;
    logic       seed_load;
    logic [3:0] seed_val;
    logic [3:0] lfsr_state_out;
    logic       lfsr_out;
    logic       rx_valid;
    logic       rx_bit;
    logic       cnt_clr;
    logic       chk_locked;
    logic       chk_err;
    logic [1:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    lfsr_prbs_engine #(
        .LFSR_LENGTH    (4),
        .LFSR_PRIM_POLY (4'b1101),
        .LFSR_SEED_VAL  (4'b1011),
        .LOCK_COUNT     (4),
        .LOSS_THRESH    (2),
        .ERR_CNT_W      (2)
    ) dut (
        .lfsr_clk       (lfsr_clk),
        .reset          (reset),
        .lfsr_en        (lfsr_en),
        .seed_load      (seed_load),
        .seed_val       (seed_val),
        .lfsr_state_out (lfsr_state_out),
        .lfsr_out       (lfsr_out),
        .rx_valid       (rx_valid),
        .rx_bit         (rx_bit),
        .cnt_clr        (cnt_clr),
        .chk_locked     (chk_locked),
        .chk_err        (chk_err),
        .err_cnt        (err_cnt)
    );

    initial lfsr_clk = 1'b0;
    always #5 lfsr_clk = ~lfsr_clk;

    typedef struct {
        logic       ld;
        logic       en;
        logic [3:0] sv;
        logic [3:0] exp;
    } gvec_t;

    gvec_t gv[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge lfsr_clk);
        #1;
    endtask

    // One loopback bit: generator steps and its output is fed back,
    // optionally inverted, with an optional counter clear.
    task automatic lb_bit(input logic flip, input logic clr);
        lfsr_en  = 1'b1;
        rx_valid = 1'b1;
        rx_bit   = lfsr_out ^ flip;
        cnt_clr  = clr;
        tick();
        cnt_clr  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic saw_lock;

        // Generator table: full period, hold, and seed-load cases.
        gv[0]  = '{1'b0, 1'b1, 4'h0, 4'b0111};
        gv[1]  = '{1'b0, 1'b1, 4'h0, 4'b1111};
        gv[2]  = '{1'b0, 1'b1, 4'h0, 4'b1110};
        gv[3]  = '{1'b0, 1'b1, 4'h0, 4'b1100};
        gv[4]  = '{1'b0, 1'b1, 4'h0, 4'b1000};
        gv[5]  = '{1'b0, 1'b1, 4'h0, 4'b0001};
        gv[6]  = '{1'b0, 1'b1, 4'h0, 4'b0010};
        gv[7]  = '{1'b0, 1'b1, 4'h0, 4'b0100};
        gv[8]  = '{1'b0, 1'b1, 4'h0, 4'b1001};
        gv[9]  = '{1'b0, 1'b1, 4'h0, 4'b0011};
        gv[10] = '{1'b0, 1'b1, 4'h0, 4'b0110};
        gv[11] = '{1'b0, 1'b1, 4'h0, 4'b1101};
        gv[12] = '{1'b0, 1'b1, 4'h0, 4'b1010};
        gv[13] = '{1'b0, 1'b1, 4'h0, 4'b0101};
        gv[14] = '{1'b0, 1'b1, 4'h0, 4'b1011};
        gv[15] = '{1'b0, 1'b0, 4'h0, 4'b1011};
        gv[16] = '{1'b1, 1'b0, 4'h6, 4'b0110};
        gv[17] = '{1'b1, 1'b0, 4'h0, 4'b1011};
        gv[18] = '{1'b1, 1'b1, 4'h6, 4'b0110};
        gv[19] = '{1'b0, 1'b1, 4'h0, 4'b1101};
        gv[20] = '{1'b0, 1'b0, 4'h0, 4'b1101};

        reset     = 1'b1;
        lfsr_en   = 1'b0;
        seed_load = 1'b0;
        seed_val  = 4'h0;
        rx_valid  = 1'b0;
        rx_bit    = 1'b0;
        cnt_clr   = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(lfsr_state_out), 32'h0000000b);
        check("rst_out", 32'(lfsr_out), 32'd1);
        check("rst_locked", 32'(chk_locked), 32'd0);
        check("rst_err", 32'(chk_err), 32'd0);
        check("rst_errcnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            seed_load = gv[i].ld;
            lfsr_en   = gv[i].en;
            seed_val  = gv[i].sv;
            tick();
            check($sformatf("gen_state[%0d]", i), 32'(lfsr_state_out), 32'(gv[i].exp));
            check($sformatf("gen_out[%0d]", i), 32'(lfsr_out), 32'(gv[i].exp[3]));
        end
        seed_load = 1'b0;
        lfsr_en   = 1'b0;

        // Loopback acquisition from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            lb_bit(1'b0, 1'b0);
            check($sformatf("acq_locked[%0d]", i), 32'(chk_locked), (i == 8) ? 32'd1 : 32'd0);
            check($sformatf("acq_err[%0d]", i), 32'(chk_err), 32'd0);
        end
        check("acq_errcnt", 32'(err_cnt), 32'd0);

        // Idle cycles with garbage on rx_bit must not disturb the checker.
        lfsr_en  = 1'b0;
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_bit = ~lfsr_out;
            tick();
        end
        check("idle_locked", 32'(chk_locked), 32'd1);
        check("idle_err", 32'(chk_err), 32'd0);
        lb_bit(1'b0, 1'b0);
        check("idle_resume_locked", 32'(chk_locked), 32'd1);
        check("idle_resume_errcnt", 32'(err_cnt), 32'd0);

        // Single error while locked.
        lb_bit(1'b1, 1'b0);
        check("single_err", 32'(chk_err), 32'd1);
        check("single_errcnt", 32'(err_cnt), 32'd1);
        check("single_locked", 32'(chk_locked), 32'd1);
        lb_bit(1'b0, 1'b0);
        check("single_err_clear", 32'(chk_err), 32'd0);
        check("single_hold", 32'(chk_locked), 32'd1);

        // Two consecutive errors force loss of lock; the second is counted.
        lb_bit(1'b1, 1'b0);
        check("loss1_errcnt", 32'(err_cnt), 32'd2);
        check("loss1_locked", 32'(chk_locked), 32'd1);
        lb_bit(1'b1, 1'b0);
        check("loss2_errcnt", 32'(err_cnt), 32'd3);
        check("loss2_locked", 32'(chk_locked), 32'd0);
        check("loss2_err", 32'(chk_err), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            lb_bit(1'b0, 1'b0);
            check($sformatf("relock[%0d]", i), 32'(chk_locked), (i == 8) ? 32'd1 : 32'd0);
        end
        check("relock_errcnt_kept", 32'(err_cnt), 32'd3);

        // Clear, then isolated errors until the counter saturates.
        lb_bit(1'b0, 1'b1);
        check("clr_errcnt", 32'(err_cnt), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            lb_bit(1'b1, 1'b0);
            check($sformatf("sat_errcnt[%0d]", k), 32'(err_cnt), (k >= 3) ? 32'd3 : 32'(k));
            lb_bit(1'b0, 1'b0);
            lb_bit(1'b0, 1'b0);
            check($sformatf("sat_locked[%0d]", k), 32'(chk_locked), 32'd1);
        end
        lb_bit(1'b1, 1'b1);
        check("clr_wins_errcnt", 32'(err_cnt), 32'd0);
        check("clr_wins_err", 32'(chk_err), 32'd1);
        check("clr_wins_locked", 32'(chk_locked), 32'd1);

        // Reset in the middle of LOCKED with other inputs active.
        lb_bit(1'b0, 1'b0);
        lb_bit(1'b1, 1'b0);
        check("pre_rst_errcnt", 32'(err_cnt), 32'd1);
        reset     = 1'b1;
        seed_load = 1'b1;
        seed_val  = 4'h6;
        lb_bit(1'b1, 1'b0);
        reset     = 1'b0;
        seed_load = 1'b0;
        check("midrst_locked", 32'(chk_locked), 32'd0);
        check("midrst_errcnt", 32'(err_cnt), 32'd0);
        check("midrst_err", 32'(chk_err), 32'd0);
        check("midrst_state", 32'(lfsr_state_out), 32'h0000000b);

        // All-zero stream must never lock.
        lfsr_en  = 1'b0;
        rx_valid = 1'b1;
        rx_bit   = 1'b0;
        saw_lock = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (chk_locked) saw_lock = 1'b1;
        end
        check("zeros_never_lock", 32'(saw_lock), 32'd0);
        check("zeros_errcnt", 32'(err_cnt), 32'd0);
        rx_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
